// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline stage with registered in_ready, 2-entry skid buffer and perf counters
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  parameter int ZERO_BUBBLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] main_q, skid_q, main_nx, skid_nx;
  logic acc, pop;
  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_valid = state != EMPTY;
  assign occupancy = state == FULL ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
  assign out_data = (ZERO_BUBBLE != 0 && !out_valid) ? '0 : main_q;
  always_comb begin
    state_nx = state;
    main_nx = main_q;
    skid_nx = skid_q;
    case (state)
      EMPTY: if (acc) begin
        state_nx = ONE;
        main_nx = in_data;
      end
      ONE: if (acc && pop) main_nx = in_data;
        else if (acc) begin
          state_nx = FULL;
          skid_nx = in_data;
        end else if (pop) state_nx = EMPTY;
      FULL: if (pop) begin
        state_nx = ONE;
        main_nx = skid_q;
      end
      default: state_nx = EMPTY;
    endcase
    if (clear) begin
      state_nx = EMPTY;
      if (ZERO_BUBBLE != 0) begin
        main_nx = '0;
        skid_nx = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      in_ready <= 1'b1;
    end else begin
      state <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
      in_ready <= state_nx != FULL;
    end
  end
  // counters qualify on pre-edge handshake signals and saturate at all-ones
  always_ff @(posedge clk) begin
    if (reset || perf_clr) begin
      stall_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && out_ready && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed self-checking bench for pipe_stage_skid (CNT_W=4, ZERO_BUBBLE=1)
module tb_pipe_stage_skid;
  logic clk = 0, reset, clear, in_valid, in_ready, out_valid, out_ready, perf_clr;
  logic [31:0] in_data, out_data;
  logic [1:0] occupancy;
  logic [3:0] stall_cnt, bubble_cnt;
  int tests = 0, fails = 0;

  pipe_stage_skid #(.DATA_W(32), .CNT_W(4), .ZERO_BUBBLE(1)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .perf_clr(perf_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task step();
    @(posedge clk);
    #1;
  endtask

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task chk_state(input string tag, input logic [1:0] occ, input logic rdy, input logic vld, input logic [31:0] dat);
    chk({tag, ".occ"}, {30'd0, occupancy}, {30'd0, occ});
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, vld});
    chk({tag, ".out_data"}, out_data, dat);
  endtask

  initial begin
    reset = 1; clear = 0; in_valid = 0; in_data = 0; out_ready = 0; perf_clr = 0;
    step(); step();
    chk_state("reset", 2'd0, 1, 0, 32'h0);
    chk("reset.stall", {28'd0, stall_cnt}, 32'd0);
    chk("reset.bubble", {28'd0, bubble_cnt}, 32'd0);
    reset = 0;

    // streaming at full throughput
    out_ready = 1; in_valid = 1;
    in_data = 32'h1; step(); chk_state("stream1", 2'd1, 1, 1, 32'h1);
    in_data = 32'h2; step(); chk_state("stream2", 2'd1, 1, 1, 32'h2);
    in_data = 32'h3; step(); chk_state("stream3", 2'd1, 1, 1, 32'h3);
    in_valid = 0; step(); chk_state("drain", 2'd0, 1, 0, 32'h0);

    // backpressure fills the skid buffer
    out_ready = 0; in_valid = 1;
    in_data = 32'h11; step(); chk_state("bp1", 2'd1, 1, 1, 32'h11);
    in_data = 32'h22; step(); chk_state("bp2", 2'd2, 0, 1, 32'h11);
    in_data = 32'h33; step(); chk_state("bp_hold", 2'd2, 0, 1, 32'h11);
    out_ready = 1; step(); chk_state("bp_pop1", 2'd1, 1, 1, 32'h22);
    step(); chk_state("bp_pop2", 2'd1, 1, 1, 32'h33);
    in_valid = 0; step(); chk_state("bp_empty", 2'd0, 1, 0, 32'h0);

    // flush from FULL with a word offered
    out_ready = 0; in_valid = 1;
    in_data = 32'h11; step();
    in_data = 32'h22; step(); chk_state("cl_full", 2'd2, 0, 1, 32'h11);
    clear = 1; in_data = 32'h44; step(); chk_state("cl_flush", 2'd0, 1, 0, 32'h0);
    clear = 0; in_valid = 0; out_ready = 1; step(); chk_state("cl_after", 2'd0, 1, 0, 32'h0);

    // flush from ONE with an accept in the same cycle drops the word
    out_ready = 0; in_valid = 1; in_data = 32'h66; step(); chk_state("cl1_one", 2'd1, 1, 1, 32'h66);
    clear = 1; in_data = 32'h77; step(); chk_state("cl1_flush", 2'd0, 1, 0, 32'h0);
    clear = 0; in_valid = 0; step(); chk_state("cl1_after", 2'd0, 1, 0, 32'h0);

    // stall counter saturation and perf_clr
    perf_clr = 1; in_valid = 1; in_data = 32'hAA; step();
    chk("pc.stall0", {28'd0, stall_cnt}, 32'd0);
    chk("pc.bubble0", {28'd0, bubble_cnt}, 32'd0);
    perf_clr = 0; in_valid = 0;
    step(); step(); step();
    chk("stall3", {28'd0, stall_cnt}, 32'd3);
    for (int i = 0; i < 17; i++) step();
    chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
    chk("stall_sat.bubble", {28'd0, bubble_cnt}, 32'd0);
    chk_state("stall_hold", 2'd1, 1, 1, 32'hAA);
    perf_clr = 1; step();
    chk("perf_clr", {28'd0, stall_cnt}, 32'd0);
    perf_clr = 0;

    // bubble counting while empty
    out_ready = 1; step(); chk_state("b_empty", 2'd0, 1, 0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    chk("bubble5", {28'd0, bubble_cnt}, 32'd5);
    chk("bubble5.stall", {28'd0, stall_cnt}, 32'd0);

    // reset from FULL
    out_ready = 0; in_valid = 1;
    in_data = 32'h11; step();
    in_data = 32'h22; step();
    chk_state("r_full", 2'd2, 0, 1, 32'h11);
    chk("r_full.stall", {28'd0, stall_cnt}, 32'd1);
    reset = 1; in_data = 32'h55; step();
    chk_state("r_reset", 2'd0, 1, 0, 32'h0);
    chk("r_reset.stall", {28'd0, stall_cnt}, 32'd0);
    chk("r_reset.bubble", {28'd0, bubble_cnt}, 32'd0);
    reset = 0; in_valid = 0; out_ready = 1; step();
    chk_state("r_after", 2'd0, 1, 0, 32'h0);
    chk("r_after.bubble", {28'd0, bubble_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers: one generic elastic stage carrying a packed DATA_W-bit bundle (operands, PC, immediates, opcode fields) between any two datapath stages.
- Adds a valid/ready handshake and a 2-entry skid buffer, so upstream ready is registered and full throughput is kept under backpressure.
- Keeps flush (clear) and bubble zeroing.
- Adds saturating stall/bubble performance counters.

Parameters:
DATA_W, 32, width of the packed payload bundle
CNT_W, 16, width of each performance counter
ZERO_BUBBLE, 1, 1 = out_data forced to 0 whenever out_valid=0 (bubble reads as all-zero/NOP); 0 = out_data shows the main register unconditionally

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous flush; discards all held entries
in_valid  in  1  upstream offers in_data
in_ready  out  1  registered; stage can accept this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  out_data holds a valid entry
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  head payload
occupancy  out  2  entries held: 0, 1 or 2
perf_clr  in  1  synchronous clear of both counters
stall_cnt  out  CNT_W  cycles with out_valid=1, out_ready=0
bubble_cnt  out  CNT_W  cycles with out_valid=0, out_ready=1

Behaviour:
- Reset (highest priority; sampled at the edge): state EMPTY, main=0, skid=0, in_ready=1, out_valid=0, out_data=0, occupancy=0, stall_cnt=0, bubble_cnt=0. Reset mid-operation drops all entries.
- Transfer definitions:
  - acc = in_valid & in_ready
  - pop = out_valid & out_ready
- States:
  - EMPTY (occ 0)
  - ONE (main valid, occ 1)
  - FULL (main + skid valid, occ 2)
- Transitions, no clear:
  - EMPTY: acc -> ONE, main<=in_data; else hold.
  - ONE: acc&pop -> ONE, main<=in_data. acc&!pop -> FULL, skid<=in_data. !acc&pop -> EMPTY. Else hold.
  - FULL: in_ready=0, so acc is impossible. pop -> ONE, main<=skid. Else hold.
- in_ready is a register:
  - next = 1 unless next state is FULL.
  - in_ready=0 exactly while FULL.
  - in_ready never depends combinationally on out_ready.
- out_valid = (state != EMPTY), registered.
- out_data = main. If ZERO_BUBBLE=1 and out_valid=0, out_data=0.
- Latency: one cycle, in_data accepted at edge N appears on out_data after edge N. Sustained throughput is 1 word/cycle when out_ready=1.
- Ordering: strict FIFO; no loss, no duplication.
- clear (below reset, above handshake):
  - Next state EMPTY, in_ready=1, occupancy=0.
  - If ZERO_BUBBLE=1, main and skid are zeroed.
  - A word offered with acc in the clear cycle is dropped.
  - A pop in the clear cycle is counted as delivered downstream; no entry remains.
- Counters:
  - Each increments by 1 per qualifying cycle, saturating at 2^CNT_W-1.
  - Qualification uses pre-edge out_valid and out_ready.
  - perf_clr zeroes both counters and takes precedence over an increment in the same cycle.
  - clear does not affect the counters.
  - A cycle with clear=1 still counts per the rule above.
- No X propagation: occupancy, in_ready and out_valid are always defined after the first reset.

Test Plan:
1. Reset, then stream 0x00000001, 0x00000002, 0x00000003 on consecutive cycles with out_ready=1 -> out_data shows 1, 2, 3 on the three cycles following each accept; out_valid=1; occupancy=1; in_ready stays 1.
2. out_ready=0, offer 0x11 then 0x22 -> occupancy=2 and in_ready=0; 0x33 is held upstream. Raise out_ready -> outputs 0x11, 0x22, 0x33 in order; in_ready returns to 1 the cycle after the first pop.
3. FULL (0x11, 0x22), assert clear with in_valid=1, in_data=0x44, ZERO_BUBBLE=1 -> next cycle occupancy=0, out_valid=0, out_data=0, in_ready=1; 0x44 is never emitted.
4. CNT_W=4, one entry held, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated). Pulse perf_clr -> stall_cnt=0 next cycle.
5. EMPTY, out_ready=1 for 5 cycles -> bubble_cnt=5, stall_cnt unchanged.
6. FULL with counters nonzero, assert reset one cycle -> all outputs at reset values (in_ready=1, counters 0). A word 0x55 offered the same cycle is not emitted.
